alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, handshaked arithmetic/logic unit that succeeds the single-cycle 16-bit ALU in the datapath. It adds a generic data width, true bitwise logic, and iterative multiply/divide/remainder. Operations run under a Start/Busy/Done handshake so the control FSM can stall on multi-cycle ops. Result and Zero flag are registered and hold until the next operation completes.

## Interface
- WIDTH, 16, operand/result width in bits (≥4)
- OPW, 4, ALUOp width (fixed at 4; ops 0–15)

- CLK  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request; accepted on a CLK edge where Start=1 and Busy=0
- ALUOp  in  OPW  operation select, sampled at acceptance
- FirstInput  in  WIDTH  operand A, sampled at acceptance
- SecondInput  in  WIDTH  operand B, sampled at acceptance
- OutputData  out  WIDTH  registered result
- Zero  out  1  registered, 1 when the completed result == 0
- Busy  out  1  multi-cycle op in progress; Start ignored while high
- Done  out  1  one-cycle pulse: OutputData/Zero just updated

## Operation
- Operands and op latched at acceptance; later input changes have no effect on the op in flight.
- All arithmetic unsigned, modulo 2^WIDTH.
- Single-cycle ops:
  - 0 CLR: result 0.
  - 1 ADD: A+B.
  - 2 SUB: A−B.
  - 3 OR: bitwise A|B.
  - 4 AND: bitwise A&B.
  - 5 SLL: A<<B.
  - 6 SRL: logical A>>B.
  - 7 XOR: bitwise A^B.
  - 11–15: reserved; behave as CLR.
- Shift amount is the full B value; B ≥ WIDTH gives 0.
- Multi-cycle ops:
  - 8 MUL: low WIDTH bits of A*B; shift-add, one bit per cycle.
  - 9 DIVU: floor(A/B); restoring division, one quotient bit per cycle.
  - 10 REMU: A mod B; same datapath as DIVU.
- Divide by zero (B=0): DIVU returns all ones; REMU returns A. Still takes the full WIDTH iterations; no flag.
- Zero reflects the result of the op that completed, not A−B.
- FSM states:
  - IDLE: Busy=0. On accept of op 0–7/11–15, stay in IDLE, write the result, and pulse Done. On accept of op 8–10, load the accumulator/remainder, the shifted operand and an iteration counter = WIDTH, then go to RUN.
  - RUN: Busy=1. Each edge performs one iteration and decrements the counter. On the edge where the counter reaches 0, write OutputData/Zero, pulse Done, and return to IDLE.
- Reset: the next edge forces IDLE from any state and aborts any RUN op with no Done. Outputs become OutputData=0, Zero=0, Busy=0, Done=0. The counter and internal registers clear.
- Start and Reset high on the same edge: Reset wins; the request is dropped.

## Timing
- Single-cycle op accepted at edge k:
  - OutputData/Zero valid and Done=1 after edge k.
  - Done=0 after edge k+1 unless another op completes at that edge.
- Multi-cycle op accepted at edge k:
  - Busy=1 after edges k … k+WIDTH−1.
  - Result written and Done=1 after edge k+WIDTH, with Busy=0 in the same cycle.
  - Latency is exactly WIDTH cycles, independent of operand values.
- Back-to-back: Start may be held high. A new request is accepted in the same cycle that Done is high from a multi-cycle op, because Busy is already low. Single-cycle ops issued every cycle give Done high continuously.
- Start while Busy=1: ignored, not queued.
- OutputData and Zero hold their last written value between completions and during RUN.

## Test plan
- Reset, then idle 3 cycles: OutputData=0, Zero=0, Busy=0, Done=0 every cycle.
- Logic/shift (WIDTH=16), one op per cycle:
  - XOR 0xF0F0,0x0FF0 → 0xFF00.
  - OR 0x0003,0x0000 → 0x0003.
  - SLL 0x0001,20 → 0x0000 with Zero=1.
  - SUB 5,5 → 0 with Zero=1.
  - Each op gives Done one cycle after accept.
- Multiply and divide:
  - MUL 300,300 → 0x5F90 after exactly 16 Busy cycles, with a single Done pulse.
  - DIVU 1000,7 → 142.
  - REMU 1000,7 → 6.
- Divide by zero:
  - DIVU 1234,0 → 0xFFFF.
  - REMU 1234,0 → 1234.
  - Both have latency 16.
- Handshake:
  - Start pulsed at RUN cycle 5 with ADD 1,1: ignored, and the MUL result is unchanged.
  - Start held high across the Done cycle: the next op is accepted in that cycle.
- Reset at RUN cycle 8 of DIVU: no Done, Busy=0, OutputData=0 next cycle.
  - A subsequent ADD 2,3 yields 5 with normal 1-cycle latency.

Source files
------------

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with single-cycle logic/arith and iterative MUL/DIVU/REMU
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [OPW-1:0]   ALUOp,
  input  logic [WIDTH-1:0] FirstInput,
  input  logic [WIDTH-1:0] SecondInput,
  output logic [WIDTH-1:0] OutputData,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [OPW-1:0] OP_CLR  = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(7);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(8);
  localparam logic [OPW-1:0] OP_DIVU = OPW'(9);
  localparam logic [OPW-1:0] OP_REMU = OPW'(10);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]   op_q, op_d;
  // a: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // b: multiplier (MUL) or divisor (DIV/REM)
  // acc: product accumulator (MUL) or partial remainder (DIV/REM)
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d, done_q, done_d;

  logic             is_multi, last_iter, div_ge;
  logic [WIDTH-1:0] single_res, multi_res, mul_acc, div_rem, div_quo;
  logic [WIDTH:0]   rem_shift, rem_diff;

  assign is_multi  = (ALUOp == OP_MUL) || (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);
  assign last_iter = (cnt_q == CW'(1));

  // State register; reset aborts any op in flight
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: only multi-cycle ops leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start && is_multi) state_d = S_RUN;
      S_RUN:   if (last_iter)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy = (state_q == S_RUN);
  end

  // Single-cycle results; shifts by B >= WIDTH naturally zero-fill
  always_comb begin
    case (ALUOp)
      OP_CLR:  single_res = '0;
      OP_ADD:  single_res = FirstInput + SecondInput;
      OP_SUB:  single_res = FirstInput - SecondInput;
      OP_OR:   single_res = FirstInput | SecondInput;
      OP_AND:  single_res = FirstInput & SecondInput;
      OP_SLL:  single_res = FirstInput << SecondInput;
      OP_SRL:  single_res = FirstInput >> SecondInput;
      OP_XOR:  single_res = FirstInput ^ SecondInput;
      default: single_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring division.
  // With a zero divisor every step subtracts nothing, so the quotient
  // fills with ones and the remainder ends up equal to the dividend.
  always_comb begin
    mul_acc   = acc_q + (b_q[0] ? a_q : '0);
    rem_shift = {acc_q, a_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    div_ge    = (rem_shift >= {1'b0, b_q});
    div_rem   = WIDTH'(div_ge ? rem_diff : rem_shift);
    div_quo   = {a_q[WIDTH-2:0], div_ge};
  end

  // Datapath next-state: operand capture, iteration and result write
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    out_d     = out_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    multi_res = '0;
    if (state_q == S_IDLE) begin
      if (Start) begin
        op_d = ALUOp;
        if (is_multi) begin
          cnt_d = CW'(WIDTH);
          a_d   = FirstInput;
          b_d   = SecondInput;
          acc_d = '0;
        end else begin
          out_d  = single_res;
          zero_d = (single_res == '0);
          done_d = 1'b1;
        end
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        acc_d     = mul_acc;
        a_d       = a_q << 1;
        b_d       = b_q >> 1;
        multi_res = mul_acc;
      end else begin
        acc_d     = div_rem;
        a_d       = div_quo;
        multi_res = (op_q == OP_DIVU) ? div_quo : div_rem;
      end
      if (last_iter) begin
        out_d  = multi_res;
        zero_d = (multi_res == '0);
        done_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  assign OutputData = out_q;
  assign Zero       = zero_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         Reset, Start;
  logic [3:0]   ALUOp;
  logic [W-1:0] FirstInput, SecondInput, OutputData;
  logic         Zero, Busy, Done;

  int checks = 0;
  int errors = 0;
  int n, dones;
  logic [W-1:0] exp_v;

  always #5 CLK = ~CLK;

  alu_multicycle #(.WIDTH(W), .OPW(4)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUOp(ALUOp),
    .FirstInput(FirstInput), .SecondInput(SecondInput),
    .OutputData(OutputData), .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  function automatic logic [W-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (op)
      1:  r = ua + ub;
      2:  r = ua - ub;
      3:  r = ua | ub;
      4:  r = ua & ub;
      5:  r = (ub >= W) ? 0 : (ua << ub);
      6:  r = (ub >= W) ? 0 : (ua >> ub);
      7:  r = ua ^ ub;
      8:  r = ua * ub;
      9:  r = (ub == 0) ? 64'hFFFF : ua / ub;
      10: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start       = 1'b1;
    ALUOp       = 4'(op);
    FirstInput  = a;
    SecondInput = b;
  endtask

  // Leaves Start high so callers can chain single-cycle ops
  task automatic run_single(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e;
    e = model(op, a, b);
    issue(op, a, b);
    tick();
    check({tag, " done"}, Done, 1);
    check({tag, " busy"}, Busy, 0);
    check({tag, " data"}, OutputData, e);
    check({tag, " zero"}, Zero, (e == 0));
  endtask

  task automatic run_multi(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e;
    int cyc, dn;
    e = model(op, a, b);
    issue(op, a, b);
    tick();
    Start = 1'b0;
    FirstInput = ~a;
    SecondInput = ~b;
    cyc = 0;
    dn = 0;
    while (Busy && cyc < 64) begin
      if (Done) dn++;
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, W);
    check({tag, " early done"}, dn, 0);
    check({tag, " done"}, Done, 1);
    check({tag, " data"}, OutputData, e);
    check({tag, " zero"}, Zero, (e == 0));
    tick();
    check({tag, " done drop"}, Done, 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ALUOp = '0; FirstInput = '0; SecondInput = '0;
    tick(); tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst data", OutputData, 0);
      check("rst zero", Zero, 0);
      check("rst busy", Busy, 0);
      check("rst done", Done, 0);
      tick();
    end

    // back-to-back single-cycle ops, Start held high
    run_single("xor", 7, 16'hF0F0, 16'h0FF0);
    check("xor value", OutputData, 16'hFF00);
    run_single("or", 3, 16'h0003, 16'h0000);
    check("or value", OutputData, 16'h0003);
    run_single("sll20", 5, 16'h0001, 16'd20);
    check("sll20 zero", Zero, 1);
    run_single("sub", 2, 16'd5, 16'd5);
    check("sub zero", Zero, 1);
    run_single("add", 1, 16'hFFFF, 16'h0002);
    Start = 1'b0;
    tick();
    check("idle done", Done, 0);
    check("idle hold", OutputData, 16'h0001);

    run_multi("mul", 8, 16'd300, 16'd300);
    check("mul value", OutputData, 16'h5F90);
    run_multi("divu", 9, 16'd1000, 16'd7);
    check("divu value", OutputData, 16'd142);
    run_multi("remu", 10, 16'd1000, 16'd7);
    check("remu value", OutputData, 16'd6);
    run_multi("divu0", 9, 16'd1234, 16'd0);
    check("divu0 value", OutputData, 16'hFFFF);
    run_multi("remu0", 10, 16'd1234, 16'd0);
    check("remu0 value", OutputData, 16'd1234);

    // Start during RUN is ignored
    issue(8, 16'd300, 16'd300);
    tick();
    Start = 1'b0;
    n = 0;
    repeat (4) begin tick(); n++; end
    issue(1, 16'd1, 16'd1);
    tick(); n++;
    Start = 1'b0;
    while (Busy && n < 64) begin tick(); n++; end
    check("ign latency", n, W);
    check("ign done", Done, 1);
    check("ign data", OutputData, 16'h5F90);
    tick();
    check("ign no queue done", Done, 0);
    check("ign no queue data", OutputData, 16'h5F90);

    // Start held across the Done cycle
    issue(8, 16'd3, 16'd4);
    tick();
    issue(1, 16'd7, 16'd8);
    n = 0;
    while (Busy && n < 64) begin tick(); n++; end
    check("held mul done", Done, 1);
    check("held mul data", OutputData, 16'd12);
    tick();
    Start = 1'b0;
    check("held add done", Done, 1);
    check("held add busy", Busy, 0);
    check("held add data", OutputData, 16'd15);
    tick();
    check("held add drop", Done, 0);

    // Reset and Start on the same edge: request dropped
    issue(1, 16'd1, 16'd2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    check("rst+start done", Done, 0);
    check("rst+start data", OutputData, 0);
    tick();
    check("rst+start late done", Done, 0);

    // Reset mid-RUN aborts without Done
    run_single("pre", 1, 16'd9, 16'd9);
    issue(9, 16'd1000, 16'd7);
    tick();
    Start = 1'b0;
    repeat (7) tick();
    check("abort busy pre", Busy, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort done", Done, 0);
    check("abort busy", Busy, 0);
    check("abort data", OutputData, 0);
    check("abort zero", Zero, 0);
    dones = 0;
    repeat (20) begin tick(); if (Done || Busy) dones++; end
    check("abort quiet", dones, 0);
    run_single("after abort", 1, 16'd2, 16'd3);
    check("after abort value", OutputData, 16'd5);
    Start = 1'b0;
    tick();

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [W-1:0] a, b;
      op = $urandom_range(0, 15);
      a  = W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if (op >= 8 && op <= 10) begin
        run_multi("rnd multi", op, a, b);
      end else begin
        exp_v = model(op, a, b);
        run_single("rnd single", op, a, b);
        Start = 1'b0;
        tick();
        check("rnd single drop", Done, 0);
        check("rnd single hold", OutputData, exp_v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
